pila_retorno: RTL and testbench
===============================

Name: pila_retorno

Overview:
Hardware return-address stack (LIFO) for subroutine CALL/RET in the single-cycle CPU.
- Sits inside camino_datos next to the PC register and feeds the PC next-value mux.
- On CALL, the control unit pushes PC+1. On RET, the stack's top-of-stack output is selected as next PC and popped on the same clock edge.
- Overflow/underflow are reported as sticky flags for the testbench and a future exception path.

Parameters:
- WIDTH, 10, bit width of a stored return address (matches PC width).
- DEPTH, 8, number of entries; must be ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- push  input  1  CALL strobe from control unit; one push per cycle asserted.
- pop  input  1  RET strobe from control unit; one pop per cycle asserted.
- d_in  input  WIDTH  return address to push (PC+1 from datapath).
- tos  output  WIDTH  current top-of-stack, combinational from stored state.
- level  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- empty  output  1  level == 0.
- full  output  1  level == DEPTH.
- ovf  output  1  sticky: push attempted while full.
- unf  output  1  sticky: pop attempted while empty.

Behaviour:
Storage and outputs
- Storage: DEPTH×WIDTH register array plus stack pointer sp (= level).
- No RAM inference is required.
- tos = mem[sp-1] when sp > 0, else 0. It is purely combinational, so RET reads the address in the same cycle pop is asserted (zero read latency, as the single-cycle CPU requires).

Reset
- Synchronous: on rising edge with reset=1, sp ← 0, ovf ← 0, unf ← 0.
- Array contents are don't-care but must not leak: tos = 0, empty = 1, full = 0, level = 0.
- Reset overrides push/pop in the same cycle.

Per-edge update (reset=0), decided by {push, pop}:
- 00: hold.
- 10, not full: mem[sp] ← d_in; sp ← sp+1.
- 10, full: no write, sp held, ovf ← 1. Existing entries are preserved, never overwritten or wrapped.
- 01, not empty: sp ← sp−1. The entry is not cleared.
- 01, empty: sp held at 0, unf ← 1. sp must never wrap to DEPTH.
- 11, not empty: replace top, mem[sp-1] ← d_in; sp unchanged; no flags. This covers RET immediately followed by CALL within one instruction, which cannot occur today but is defined.
- 11, empty: treated as a plain push (mem[0] ← d_in, sp ← 1); unf not set.

Flags
- ovf/unf stay set until reset; further legal operations do not clear them.

Width rules
- sp/level width is $clog2(DEPTH+1), so level can represent DEPTH exactly.
- d_in is stored unmodified; no arithmetic is performed on addresses.

Decomposition:
- Shared package/include (constantes.vh): PC_WIDTH (=10) and STACK_DEPTH (=8) defines. camino_datos instantiates pila_retorno with these, and the control unit's CALL/RET opcode constants live there too.
- Single module; no sub-module is warranted.
- Integration change outside this block: the PC mux gains a third input (tos), selected by the control unit on RET.

Test Plan:
1. Reset: reset=1 for one edge with push=1, d_in=10'h3FF → level=0, empty=1, tos=0, ovf=0, unf=0.
2. Push/pop order: push 10'd5, 10'd17, 10'd200 on consecutive edges → tos 5, 17, 200 and level 1, 2, 3. Three pops → tos 17, 5, 0; empty=1.
3. Overflow (DEPTH=8): push 1..8 → full=1, tos=8. Push 99 → tos still 8, level=8, ovf=1. Pop → tos=7, ovf stays 1.
4. Underflow: from empty, pop → level=0, tos=0, unf=1. Then push 42 → tos=42, level=1, unf still 1.
5. Simultaneous: with stack {5, 17}, push&pop d_in=300 → tos=300, level=2; pop → tos=5. From empty, push&pop d_in=7 → tos=7, level=1, unf=0.
6. CPU integration (full cpu testbench, 60 ns clock): program with CALL at address 2 to a subroutine that writes R3 and RETs. After 9 cycles, PC returns to 3, R3 holds the written value, and pila_retorno.level=0.

Source files
------------

// File: rtl/pila_retorno_pkg.sv
// pila_retorno_pkg: constants and types shared by the return-address stack.
//   PC_WIDTH    - default width of a stored return address (PC width)
//   STACK_DEPTH - default number of stack entries
//   pila_op_e   - stack operation as decoded from {push, pop}
package pila_retorno_pkg;

    localparam int PC_WIDTH    = 10;
    localparam int STACK_DEPTH = 8;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11   // pop and push together: overwrite the top entry
    } pila_op_e;

endpackage

// File: rtl/pila_retorno.sv
// pila_retorno: hardware return-address stack (LIFO) for CALL/RET.
// Ports:
//   clk    - system clock, rising-edge state updates
//   reset  - synchronous active-high reset (sp and flags cleared)
//   push   - CALL strobe, pushes d_in
//   pop    - RET strobe, pops the top entry
//   d_in   - return address to push
//   tos    - top of stack, combinational (0 when empty)
//   level  - number of valid entries, 0..DEPTH
//   empty  - level == 0
//   full   - level == DEPTH
//   ovf    - sticky: push attempted while full
//   unf    - sticky: pop attempted while empty
module pila_retorno
    import pila_retorno_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           d_in,
    output logic [WIDTH-1:0]           tos,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);

    localparam int LW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [LW-1:0]               sp;
    logic [IW-1:0]               top_idx;
    logic [IW-1:0]               wr_idx;
    logic                        wr_en;
    pila_op_e                    op;

    assign op      = pila_op_e'({push, pop});
    assign empty   = (sp == '0);
    assign full    = (sp == LW'(DEPTH));
    assign level   = sp;
    // Only meaningful when sp > 0; truncation is safe since sp-1 < DEPTH.
    assign top_idx = IW'(sp - LW'(1));
    // Stale entries above sp are never visible: tos is forced to 0 when empty.
    assign tos     = empty ? '0 : mem[top_idx];

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = IW'(sp);
        unique case (op)
            OP_PUSH: wr_en = !full;
            OP_REPL: begin
                wr_en = 1'b1;
                // Replace the top in place; on an empty stack this is a push to slot 0.
                if (!empty) wr_idx = top_idx;
            end
            default: wr_en = 1'b0;
        endcase
        if (reset) wr_en = 1'b0;
    end

    // Storage has no reset; contents are hidden by sp until rewritten.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= d_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            unique case (op)
                OP_HOLD: ;
                OP_PUSH: begin
                    if (full) ovf <= 1'b1;
                    else      sp  <= sp + LW'(1);
                end
                OP_POP: begin
                    if (empty) unf <= 1'b1;
                    else       sp  <= sp - LW'(1);
                end
                OP_REPL: begin
                    if (empty) sp <= LW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pila_retorno.sv
// tb_pila_retorno: self-checking bench for pila_retorno. Each step drives
// push/pop/d_in, updates a queue-based reference stack, and queues the
// expected post-edge outputs; after the edge the entry is popped and compared.
module tb_pila_retorno;

    localparam int W  = 10;
    localparam int D  = 8;
    localparam int LW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          reset, push, pop;
    logic [W-1:0]  d_in;
    logic [W-1:0]  tos;
    logic [LW-1:0] level;
    logic          empty, full, ovf, unf;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0]  tos;
        logic [LW-1:0] lvl;
        logic          e, f, o, u;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] mstk[$];
    bit           movf, munf;

    always #5 clk = ~clk;

    pila_retorno #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .d_in(d_in),
        .tos(tos), .level(level), .empty(empty), .full(full),
        .ovf(ovf), .unf(unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit p, input bit q, input logic [W-1:0] d);
        if (r) begin
            mstk.delete();
            movf = 0;
            munf = 0;
        end else if (p && !q) begin
            if (mstk.size() < D) mstk.push_back(d);
            else                 movf = 1;
        end else if (!p && q) begin
            if (mstk.size() > 0) void'(mstk.pop_back());
            else                 munf = 1;
        end else if (p && q) begin
            if (mstk.size() > 0) mstk[mstk.size()-1] = d;
            else                 mstk.push_back(d);
        end
    endtask

    task automatic step(input string tag, input bit r, input bit p, input bit q,
                        input logic [W-1:0] d);
        exp_t e, got;
        reset = r; push = p; pop = q; d_in = d;
        model(r, p, q, d);
        e.tos = (mstk.size() > 0) ? mstk[mstk.size()-1] : '0;
        e.lvl = LW'(mstk.size());
        e.e   = (mstk.size() == 0);
        e.f   = (mstk.size() == D);
        e.o   = movf;
        e.u   = munf;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        reset = 0; push = 0; pop = 0;
        got = sbq.pop_front();
        chk({tag, ".tos"},   32'(tos),   32'(got.tos));
        chk({tag, ".level"}, 32'(level), 32'(got.lvl));
        chk({tag, ".empty"}, 32'(empty), 32'(got.e));
        chk({tag, ".full"},  32'(full),  32'(got.f));
        chk({tag, ".ovf"},   32'(ovf),   32'(got.o));
        chk({tag, ".unf"},   32'(unf),   32'(got.u));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; push = 0; pop = 0; d_in = '0;
        @(negedge clk);

        // Reset wins over a simultaneous push.
        step("rst", 1, 1, 0, 10'h3FF);
        chk("rst.tos0", 32'(tos), 0);
        chk("rst.lvl0", 32'(level), 0);

        // LIFO order.
        step("p5",   0, 1, 0, 10'd5);
        step("p17",  0, 1, 0, 10'd17);
        step("p200", 0, 1, 0, 10'd200);
        chk("ord.tos200", 32'(tos), 200);
        chk("ord.lvl3",   32'(level), 3);
        // tos is combinational: visible while pop is asserted, before the edge.
        pop = 1; #1;
        chk("ord.tos_comb", 32'(tos), 200);
        step("o1", 0, 0, 1, '0);
        chk("ord.tos17", 32'(tos), 17);
        step("o2", 0, 0, 1, '0);
        step("o3", 0, 0, 1, '0);
        chk("ord.empty", 32'(empty), 1);

        // Overflow.
        for (int i = 1; i <= D; i++) step("fill", 0, 1, 0, W'(i));
        chk("ovf.full", 32'(full), 1);
        chk("ovf.tos8", 32'(tos), 8);
        step("ovf", 0, 1, 0, 10'd99);
        chk("ovf.tos_kept", 32'(tos), 8);
        chk("ovf.flag", 32'(ovf), 1);
        step("ovf_pop", 0, 0, 1, '0);
        chk("ovf.tos7", 32'(tos), 7);
        chk("ovf.sticky", 32'(ovf), 1);

        // Underflow.
        step("rst2", 1, 0, 0, '0);
        step("unf", 0, 0, 1, '0);
        chk("unf.lvl0", 32'(level), 0);
        chk("unf.flag", 32'(unf), 1);
        step("unf_p42", 0, 1, 0, 10'd42);
        chk("unf.tos42", 32'(tos), 42);
        chk("unf.sticky", 32'(unf), 1);

        // Simultaneous push&pop.
        step("rst3", 1, 0, 0, '0);
        step("s5",  0, 1, 0, 10'd5);
        step("s17", 0, 1, 0, 10'd17);
        step("s300", 0, 1, 1, 10'd300);
        chk("sim.tos300", 32'(tos), 300);
        chk("sim.lvl2",   32'(level), 2);
        step("s_pop", 0, 0, 1, '0);
        chk("sim.tos5", 32'(tos), 5);
        step("rst4", 1, 0, 0, '0);
        step("s7", 0, 1, 1, 10'd7);
        chk("sim.tos7", 32'(tos), 7);
        chk("sim.lvl1", 32'(level), 1);
        chk("sim.unf0", 32'(unf), 0);

        // Random traffic against the reference stack.
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom),
                 W'($urandom));
        end

        if (sbq.size() != 0) chk("sbq.drained", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
